// File: rtl/step_seq_pkg.sv
// -----------------------------------------------------------------------------
// step_seq_pkg
// Shared definitions for the PS/2 receive path and the key decoders behind it.
//   - ps2_state_t    : frame FSM states (IDLE, DATA, PARITY, STOP)
//   - PS2_FRAME_BITS : bits in one PS/2 frame (start + 8 data + parity + stop)
//   - PS2_DATA_BITS  : payload bits per frame
//   - KEY_*          : scan-code constants used by downstream decoders
//   - oddParityOk()  : odd-parity test over a data byte plus its parity bit
// Optional feature macro (used by ps2_receiver): PS2_PARITY_CHECK_EN
// -----------------------------------------------------------------------------
package step_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;
    // Start, parity and stop wrap the payload.
    localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    localparam logic [7:0] KEY_RELEASE = 8'hF0;
    localparam logic [7:0] KEY_1D      = 8'h1D;
    localparam logic [7:0] KEY_1B      = 8'h1B;
    localparam logic [7:0] KEY_1C      = 8'h1C;
    localparam logic [7:0] KEY_23      = 8'h23;
    localparam logic [7:0] KEY_29      = 8'h29;

    // A frame has good parity when data plus parity holds an odd number of ones.
    function automatic logic oddParityOk(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// -----------------------------------------------------------------------------
// ps2_sync
// Brings the raw PS/2 clock and data pins into the system clock domain with
// two-flop synchronizers and flags falling edges of the synchronized clock.
// Both pins pass through the same number of flops, so the data level seen on
// a flagged edge is the level the device held while it dropped the clock.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-high reset (flops preset to bus idle 1)
//   i_clkPin   in  raw PS2_CLK
//   i_datPin   in  raw PS2_DAT
//   o_dat      out synchronized PS2_DAT
//   o_clkFall  out one-cycle pulse on a synchronized PS2_CLK falling edge
// -----------------------------------------------------------------------------
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_clkPin,
    input  logic i_datPin,
    output logic o_dat,
    output logic o_clkFall
);

    logic [1:0] r_clkSync;
    logic [1:0] r_datSync;
    logic       r_clkPrev;

    // Synchronizer chains plus one extra clock stage for edge detection.
    // Reset value 1 matches the idle bus so no false edge follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkSync <= 2'b11;
            r_datSync <= 2'b11;
            r_clkPrev <= 1'b1;
        end else begin
            r_clkSync <= {r_clkSync[0], i_clkPin};
            r_datSync <= {r_datSync[0], i_datPin};
            r_clkPrev <= r_clkSync[1];
        end
    end

    assign o_dat     = r_datSync[1];
    assign o_clkFall = r_clkPrev & ~r_clkSync[1];

endmodule

// File: rtl/ps2_receiver.sv
// -----------------------------------------------------------------------------
// ps2_receiver
// Receives 11-bit PS/2 keyboard frames and presents each accepted byte with a
// one-cycle strobe. Rejected frames (bad stop bit, optionally bad parity) and
// frames that stall longer than TIMEOUT_CYCLES give a one-cycle error strobe.
// Parameters:
//   TIMEOUT_CYCLES  idle system cycles between PS2_CLK falls that abort a frame
// Ports:
//   Clock      in  system clock, all state on the rising edge
//   Reset      in  asynchronous active-high reset
//   PS2_CLK    in  raw keyboard clock (asynchronous)
//   PS2_DAT    in  raw keyboard data (asynchronous)
//   data       out last accepted byte, held until the next accepted frame
//   data_en    out one-cycle strobe: new byte on data
//   frame_err  out one-cycle strobe: frame rejected or aborted
// Configuration macro:
//   PS2_PARITY_CHECK_EN  defined   -> odd parity must hold or the frame is rejected
//                        undefined -> parity bit captured but not checked
// -----------------------------------------------------------------------------
module ps2_receiver
    import step_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       data_en,
    output logic       frame_err
);

    localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0]      LAST_BIT = 3'(PS2_DATA_BITS - 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_CHECK = 1'b1;
`else
    localparam bit PARITY_CHECK = 1'b0;
`endif

    ps2_state_t    r_state;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_timeout;

    logic w_dat;
    logic w_clkFall;
    logic w_parityOk;
    logic w_timedOut;

    ps2_sync u_sync (
        .clk       (Clock),
        .rst       (Reset),
        .i_clkPin  (PS2_CLK),
        .i_datPin  (PS2_DAT),
        .o_dat     (w_dat),
        .o_clkFall (w_clkFall)
    );

    assign w_parityOk = !PARITY_CHECK || oddParityOk(r_shift, r_parity);
    assign w_timedOut = (r_state != IDLE) && (r_timeout == TO_MAX);

    // Frame FSM with registered strobes. A stalled frame is abandoned before
    // any edge in the same cycle is considered, so an abort always wins.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_bitCnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_timeout <= '0;
            data      <= 8'h00;
            data_en   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            data_en   <= 1'b0;
            frame_err <= 1'b0;

            // Watchdog only runs inside a frame; it saturates rather than wraps.
            if (r_state == IDLE || w_clkFall) begin
                r_timeout <= '0;
            end else if (r_timeout != TO_MAX) begin
                r_timeout <= r_timeout + 1'b1;
            end

            if (w_timedOut) begin
                r_state   <= IDLE;
                r_bitCnt  <= 3'd0;
                frame_err <= 1'b1;
            end else if (w_clkFall) begin
                case (r_state)
                    IDLE: begin
                        // A high level on a falling edge is not a start bit.
                        if (!w_dat) begin
                            r_state  <= DATA;
                            r_bitCnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        r_shift <= {w_dat, r_shift[7:1]};
                        if (r_bitCnt == LAST_BIT) begin
                            r_state <= PARITY;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        r_parity <= w_dat;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (w_dat && w_parityOk) begin
                            data    <= r_shift;
                            data_en <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
